serial_adder: RTL and testbench

Bit-serial, parametrised add/subtract unit built around one instance of the team's 1-bit `full_adder` cell and a carry flip-flop. It processes WIDTH-bit operands LSB-first, one bit per clock, and trades latency for area relative to a ripple-carry array. It sits next to the existing combinational adder as its sequential successor. A start/busy/done handshake lets a controller issue back-to-back operations.

---
 rtl/serial_adder_pkg.sv | 15 +
 rtl/serial_adder_full_adder.sv | 13 +
 rtl/serial_adder.sv | 90 +++++++++
 tb/tb_serial_adder.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial add/subtract unit.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit counter width; the terminal count is WIDTH-1, so $clog2 suffices.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder cell; the bit-slice datapath of the serial adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit add/subtract, LSB first, one bit per clock.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic             cy;
    logic [CW-1:0]    cnt;
    logic             fa_sum;
    logic             fa_carry;

    full_adder u_fa (
        .a     (sa[0]),
        .b     (sb[0]),
        .c     (cy),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            cy    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Subtract is a + ~b + 1 - cin, so invert b and cin.
                        sa    <= a;
                        sb    <= sub ? ~b : b;
                        cy    <= cin ^ sub;
                        cnt   <= '0;
                        sum   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    sum <= {fa_sum, sum[WIDTH-1:1]};
                    cy  <= fa_carry;
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        ovf   <= cy ^ fa_carry;
                        cout  <= fa_carry;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Randomized and directed bench for serial_adder at WIDTH=8 and WIDTH=5.
module tb_serial_adder;
    import serial_adder_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, cin8, sub8, busy8, done8, cout8, ovf8;
    logic [7:0] a8, b8, sum8;
    logic       start5, cin5, sub5, busy5, done5, cout5, ovf5;
    logic [4:0] a5, b5, sum5;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .cin(cin8), .sub(sub8), .busy(busy8), .done(done8),
        .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    serial_adder #(.WIDTH(5)) u_dut5 (
        .clk(clk), .rst(rst), .start(start5), .a(a5), .b(b5),
        .cin(cin5), .sub(sub5), .busy(busy5), .done(done5),
        .sum(sum5), .cout(cout5), .ovf(ovf5)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Returns {cout, ovf, sum[7:0]} from plain integer arithmetic.
    function automatic logic [9:0] ref_op(input int w, input int ra,
                                          input int rb, input int rc,
                                          input int rs);
        int m, full, res, va, vb, sr;
        logic [7:0] s8;
        m    = 1 << w;
        full = rs ? ra + (m - 1 - rb) + (1 - rc) : ra + rb + rc;
        res  = full % m;
        va   = (ra >= m / 2) ? ra - m : ra;
        vb   = (rb >= m / 2) ? rb - m : rb;
        sr   = rs ? va - vb - rc : va + vb + rc;
        s8   = 8'(res);
        return {full >= m, (sr < -m / 2) || (sr >= m / 2), s8};
    endfunction

    // One WIDTH=8 operation; optional stray start during RUN.
    task automatic run8(input string tag, input logic [7:0] oa,
                        input logic [7:0] ob, input logic oc,
                        input logic os, input bit inj);
        int lat, bc;
        logic [9:0] exp;
        exp = ref_op(8, int'(oa), int'(ob), int'(oc), int'(os));
        @(negedge clk);
        a8 = oa; b8 = ob; cin8 = oc; sub8 = os; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        lat = 1;
        bc  = 0;
        while (!done8 && lat < 30) begin
            if (busy8) bc++;
            if (inj && lat == 3) begin
                a8 = ~oa; b8 = oa ^ ob; sub8 = ~os; start8 = 1'b1;
            end else begin
                start8 = 1'b0;
            end
            lat++;
            @(negedge clk);
        end
        start8 = 1'b0;
        chk({tag, "_done"}, 32'(done8), 32'd1);
        chk({tag, "_lat"}, lat, 9);
        chk({tag, "_busy"}, bc, 8);
        chk({tag, "_res"}, {cout8, ovf8, sum8}, exp);
        @(negedge clk);
        chk({tag, "_pulse"}, {busy8, done8}, 2'b00);
        chk({tag, "_hold"}, {cout8, ovf8, sum8}, exp);
    endtask

    initial begin
        int k;
        logic [9:0] exp;
        logic [9:0] pend;
        int prev_a, prev_b, prev_c, prev_s;

        rst = 1'b1;
        start8 = 0; a8 = 0; b8 = 0; cin8 = 0; sub8 = 0;
        start5 = 0; a5 = 0; b5 = 0; cin5 = 0; sub5 = 0;
        repeat (2) @(negedge clk);
        chk("reset_out", {busy8, done8, cout8, ovf8, sum8}, 12'h0);
        chk("reset_state", 32'(u_dut8.state), 32'(IDLE));
        rst = 1'b0;

        run8("add", 8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0);
        chk("add_vec", {cout8, ovf8, sum8}, {2'b01, 8'h96});
        run8("wrap", 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        chk("wrap_vec", {cout8, ovf8, sum8}, {2'b10, 8'h00});
        run8("cin", 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("cin_vec", sum8, 8'h01);
        run8("sub1", 8'h10, 8'h20, 1'b0, 1'b1, 1'b0);
        chk("sub1_vec", {cout8, ovf8, sum8}, {2'b00, 8'hF0});
        run8("sub2", 8'h80, 8'h01, 1'b0, 1'b1, 1'b0);
        chk("sub2_vec", {cout8, ovf8, sum8}, {2'b11, 8'h7F});
        run8("ignore", 8'h21, 8'h42, 1'b0, 1'b0, 1'b1);
        chk("ignore_vec", sum8, 8'h63);

        // Reset during RUN aborts the operation.
        @(negedge clk);
        a8 = 8'h11; b8 = 8'h22; cin8 = 0; sub8 = 0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_out", {busy8, done8, cout8, ovf8, sum8}, 12'h0);
        chk("rst_state", 32'(u_dut8.state), 32'(IDLE));
        k = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) k++;
        end
        chk("rst_nodone", k, 0);

        // Reset and start together: reset wins.
        rst = 1'b1; start8 = 1'b1;
        @(negedge clk);
        rst = 1'b0; start8 = 1'b0;
        chk("rst_start", {busy8, u_dut8.state}, {1'b0, IDLE});
        run8("fresh", 8'hC8, 8'h64, 1'b1, 1'b0, 1'b0);

        // Back-to-back with start held high.
        @(negedge clk);
        a8 = 8'h01; b8 = 8'h02; cin8 = 0; sub8 = 0; start8 = 1'b1;
        @(negedge clk);
        a8 = 8'h03; b8 = 8'h04;
        k = 1;
        while (!done8 && k < 30) begin @(negedge clk); k++; end
        chk("b2b_first", {done8, sum8}, {1'b1, 8'h03});
        @(negedge clk);
        start8 = 1'b0;
        k = 1;
        while (!done8 && k < 30) begin @(negedge clk); k++; end
        chk("b2b_second", {done8, sum8}, {1'b1, 8'h07});
        chk("b2b_gap", k, 9);

        for (int i = 0; i < 150; i++) begin
            run8("rand", 8'($urandom), 8'($urandom), 1'($urandom),
                 1'($urandom), ($urandom_range(0, 7) == 0));
        end

        // Exhaustive WIDTH=5 sweep, back-to-back.
        @(negedge clk);
        {sub5, cin5, a5, b5} = 12'd0;
        start5 = 1'b1;
        for (int idx = 1; idx <= 4096; idx++) begin
            prev_a = int'(a5); prev_b = int'(b5);
            prev_c = int'(cin5); prev_s = int'(sub5);
            pend = ref_op(5, prev_a, prev_b, prev_c, prev_s);
            k = 0;
            do begin @(negedge clk); k++; end while (!done5 && k < 20);
            chk("w5_done", {done5, 5'(k)}, {1'b1, 5'd6});
            exp = {pend[9:8], 3'b000, pend[4:0]};
            chk("w5_res", {cout5, ovf5, 3'b000, sum5}, exp);
            if (idx < 4096) {sub5, cin5, a5, b5} = 12'(idx);
            else start5 = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
